// File: rtl/i2c_target_rx.sv
// I2C target receiver/transmitter: oversampled bus front end, 7-bit address match,
// receive FIFO for write transfers and valid/ready byte source for read transfers.
module i2c_target_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h10,
  parameter int DATAWIDTH  = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          scl_in,
  input  logic                          sda_in,
  output logic                          sda_oe,
  output logic [DATAWIDTH-1:0]          rx_data,
  output logic                          rx_empty,
  input  logic                          rx_pop,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  input  logic [DATAWIDTH-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          busy,
  output logic                          rx_overflow
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = $clog2(DATAWIDTH) + 1;

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACKCHK
  } state_t;

  // Bit 0/1 form the synchronizer, bit 2 is the history flop; idle-high on reset
  // so that leaving reset never looks like a bus condition.
  logic [2:0] scl_sync_q, sda_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], scl_in};
      sda_sync_q <= {sda_sync_q[1:0], sda_in};
    end
  end

  logic scl_rise, scl_fall, bus_start, bus_stop, sda_s;
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
  assign bus_start = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[2] & ~sda_sync_q[1];
  assign bus_stop  = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] & sda_sync_q[1];

  state_t                state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic [DATAWIDTH-1:0]  shift_q, shift_d;
  logic                  sda_oe_q, sda_oe_d;
  logic                  busy_q, busy_d;
  logic                  rw_q, rw_d;
  logic                  phase_q, phase_d;
  logic                  wr_pend_q, wr_pend_d;
  logic                  ack_ok_q, ack_ok_d;
  logic                  ovf_q, ovf_d;
  logic                  tx_ready_q, tx_ready_d;

  logic [DATAWIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  fifo_full, pop_eff, push_ok, push;
  logic [DATAWIDTH-1:0]  tx_byte;

  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign pop_eff   = rx_pop && (count_q != '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept the byte.
  assign push_ok   = !fifo_full || pop_eff;
  assign push      = wr_pend_q && push_ok;
  assign tx_byte   = tx_valid ? tx_data : '1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    phase_d    = phase_q;
    wr_pend_d  = 1'b0;
    ack_ok_d   = ack_ok_q;
    ovf_d      = ovf_q;
    tx_ready_d = 1'b0;

    if (wr_pend_q) begin
      ack_ok_d = push_ok;
      if (!push_ok) ovf_d = 1'b1;
    end

    if (bus_start) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      phase_d  = 1'b0;
    end else if (bus_stop) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      phase_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: if (scl_rise) begin
          shift_d = {shift_q[DATAWIDTH-2:0], sda_s};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNTW'(DATAWIDTH-1)) begin
            if (shift_q[DATAWIDTH-2:0] == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              busy_d  = 1'b1;
              rw_d    = sda_s;
              phase_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = 1'b1;
            phase_d  = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (rw_q) begin
              // The falling edge that ends the ACK also launches the first data bit.
              state_d    = TX_BYTE;
              shift_d    = tx_byte;
              sda_oe_d   = ~tx_byte[DATAWIDTH-1];
              cnt_d      = CNTW'(1);
              tx_ready_d = tx_valid;
            end else begin
              state_d  = RX_BYTE;
              sda_oe_d = 1'b0;
              cnt_d    = '0;
            end
          end
        end
        RX_BYTE: if (scl_rise) begin
          shift_d = {shift_q[DATAWIDTH-2:0], sda_s};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNTW'(DATAWIDTH-1)) begin
            state_d   = RX_ACK;
            wr_pend_d = 1'b1;
            phase_d   = 1'b0;
            cnt_d     = '0;
          end
        end
        RX_ACK: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = ack_ok_q;
            phase_d  = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
            state_d  = RX_BYTE;
            cnt_d    = '0;
          end
        end
        TX_BYTE: if (scl_fall) begin
          if (cnt_q == CNTW'(DATAWIDTH)) begin
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
            state_d  = TX_ACKCHK;
          end else begin
            shift_d  = {shift_q[DATAWIDTH-2:0], 1'b0};
            sda_oe_d = ~shift_q[DATAWIDTH-2];
            cnt_d    = cnt_q + 1'b1;
          end
        end
        TX_ACKCHK: begin
          if (!phase_q) begin
            if (scl_rise) begin
              if (!sda_s) phase_d = 1'b1;
              else        state_d = IDLE;
            end
          end else if (scl_fall) begin
            phase_d    = 1'b0;
            state_d    = TX_BYTE;
            shift_d    = tx_byte;
            sda_oe_d   = ~tx_byte[DATAWIDTH-1];
            cnt_d      = CNTW'(1);
            tx_ready_d = tx_valid;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop_eff)      count_d = count_q + 1'b1;
    else if (!push && pop_eff) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
      phase_q    <= 1'b0;
      wr_pend_q  <= 1'b0;
      ack_ok_q   <= 1'b0;
      ovf_q      <= 1'b0;
      tx_ready_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      phase_q    <= phase_d;
      wr_pend_q  <= wr_pend_d;
      ack_ok_q   <= ack_ok_d;
      ovf_q      <= ovf_d;
      tx_ready_q <= tx_ready_d;
      count_q    <= count_d;
      if (push)    wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_eff) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= shift_q;
  end

  assign sda_oe      = sda_oe_q;
  assign rx_data     = fifo_mem[rd_ptr_q];
  assign rx_empty    = (count_q == '0);
  assign rx_count    = count_q;
  assign tx_ready    = tx_ready_q;
  assign busy        = busy_q;
  assign rx_overflow = ovf_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: a bit-banged I2C master drives two targets
// (8-entry and 4-entry FIFO), each on its own open-drain SDA line.
module tb_i2c_target_rx;

  localparam int Q = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       m_scl, m_sda;
  logic       sel4;
  logic       oe8, oe4;
  logic       line8, line4, line;
  logic [7:0] rx_data8, rx_data4;
  logic       rx_empty8, rx_empty4;
  logic       rx_pop8, rx_pop4;
  logic [3:0] rx_count8;
  logic [2:0] rx_count4;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready8, tx_ready4;
  logic       busy8, busy4;
  logic       ovf8, ovf4;

  assign line8 = m_sda & ~oe8;
  assign line4 = m_sda & ~oe4;
  assign line  = sel4 ? line4 : line8;

  i2c_target_rx u_dut8 (
    .clk(clk), .reset(reset), .scl_in(m_scl), .sda_in(line8), .sda_oe(oe8),
    .rx_data(rx_data8), .rx_empty(rx_empty8), .rx_pop(rx_pop8), .rx_count(rx_count8),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready8),
    .busy(busy8), .rx_overflow(ovf8)
  );

  i2c_target_rx #(.FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .scl_in(m_scl), .sda_in(line4), .sda_oe(oe4),
    .rx_data(rx_data4), .rx_empty(rx_empty4), .rx_pop(rx_pop4), .rx_count(rx_count4),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready4),
    .busy(busy4), .rx_overflow(ovf4)
  );

  int checks = 0;
  int failures = 0;
  int tx_ready_total = 0;
  int oe8_cycles = 0;

  // Running activity counters; tests compare deltas across their own window.
  always @(posedge clk) begin
    if (tx_ready8) tx_ready_total++;
    if (oe8) oe8_cycles++;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; m_scl = 1'b1; m_sda = 1'b1; rx_pop8 = 1'b0; rx_pop4 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; wait_q();
    m_scl = 1'b1; wait_q(); wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    b = line; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] v, input logic mack);
    logic b;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      v = {v[6:0], b};
    end
    send_bit(mack);
  endtask

  task automatic test_reset();
    sel4 = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
    do_reset();
    checks++; if (oe8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_sda_oe got=%0b exp=0", oe8); end
    checks++; if (rx_empty8 !== 1'b1) begin failures++; $display("[TB] FAIL reset_rx_empty got=%0b exp=1", rx_empty8); end
    checks++; if (rx_count8 !== 4'd0) begin failures++; $display("[TB] FAIL reset_rx_count got=%0d exp=0", rx_count8); end
    checks++; if (tx_ready8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_ready got=%0b exp=0", tx_ready8); end
    checks++; if (busy8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy8); end
    checks++; if (ovf8 !== 1'b0) begin failures++; $display("[TB] FAIL reset_overflow got=%0b exp=0", ovf8); end
  endtask

  task automatic test_write_burst();
    logic ack;
    sel4 = 1'b0;
    do_reset();
    bus_start();
    send_byte(8'h20, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL wr_addr_ack got=%0b exp=0", ack); end
    checks++; if (busy8 !== 1'b1) begin failures++; $display("[TB] FAIL wr_busy got=%0b exp=1", busy8); end
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(i), ack);
      checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL wr_data_ack[%0d] got=%0b exp=0", i, ack); end
    end
    bus_stop();
    checks++; if (busy8 !== 1'b0) begin failures++; $display("[TB] FAIL wr_busy_after_stop got=%0b exp=0", busy8); end
    checks++; if (rx_count8 !== 4'd8) begin failures++; $display("[TB] FAIL wr_rx_count got=%0d exp=8", rx_count8); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (rx_data8 !== 8'(i)) begin failures++; $display("[TB] FAIL wr_pop[%0d] got=%02h exp=%02h", i, rx_data8, 8'(i)); end
      rx_pop8 = 1'b1;
      @(negedge clk);
      rx_pop8 = 1'b0;
    end
    @(negedge clk);
    checks++; if (rx_empty8 !== 1'b1) begin failures++; $display("[TB] FAIL wr_empty_after_pops got=%0b exp=1", rx_empty8); end
  endtask

  task automatic test_addr_mismatch();
    logic ack;
    int oe_before;
    sel4 = 1'b0;
    do_reset();
    oe_before = oe8_cycles;
    bus_start();
    send_byte(8'h22, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("[TB] FAIL mm_addr_nack got=%0b exp=1", ack); end
    checks++; if (busy8 !== 1'b0) begin failures++; $display("[TB] FAIL mm_busy got=%0b exp=0", busy8); end
    send_byte(8'h55, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("[TB] FAIL mm_data_nack got=%0b exp=1", ack); end
    bus_stop();
    checks++; if (oe8_cycles - oe_before !== 0) begin failures++; $display("[TB] FAIL mm_sda_driven got=%0d cycles exp=0", oe8_cycles - oe_before); end
    checks++; if (rx_count8 !== 4'd0) begin failures++; $display("[TB] FAIL mm_rx_count got=%0d exp=0", rx_count8); end
  endtask

  task automatic test_overflow();
    logic ack;
    logic [4:0] exp_ack;
    sel4 = 1'b1;
    do_reset();
    bus_start();
    send_byte(8'h20, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL ov_addr_ack got=%0b exp=0", ack); end
    exp_ack = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      send_byte(8'hA0 + 8'(i), ack);
      checks++; if (ack !== exp_ack[i]) begin failures++; $display("[TB] FAIL ov_ack[%0d] got=%0b exp=%0b", i, ack, exp_ack[i]); end
    end
    bus_stop();
    checks++; if (ovf4 !== 1'b1) begin failures++; $display("[TB] FAIL ov_flag got=%0b exp=1", ovf4); end
    checks++; if (rx_count4 !== 3'd4) begin failures++; $display("[TB] FAIL ov_rx_count got=%0d exp=4", rx_count4); end
    checks++; if (ovf8 !== 1'b0) begin failures++; $display("[TB] FAIL ov_deep_fifo_flag got=%0b exp=0", ovf8); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (rx_data4 !== 8'hA0 + 8'(i)) begin failures++; $display("[TB] FAIL ov_pop[%0d] got=%02h exp=%02h", i, rx_data4, 8'hA0 + 8'(i)); end
      rx_pop4 = 1'b1;
      @(negedge clk);
      rx_pop4 = 1'b0;
    end
    @(negedge clk);
    checks++; if (rx_empty4 !== 1'b1) begin failures++; $display("[TB] FAIL ov_empty got=%0b exp=1", rx_empty4); end
    sel4 = 1'b0;
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] v;
    logic b;
    logic [8:0] idle_bits;
    int tr_before;
    sel4 = 1'b0;
    do_reset();
    tr_before = tx_ready_total;
    tx_data = 8'hA5; tx_valid = 1'b1;
    bus_start();
    send_byte(8'h21, ack);
    tx_valid = 1'b0; tx_data = 8'h3C;
    checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL rd_addr_ack got=%0b exp=0", ack); end
    recv_byte(v, 1'b0);
    checks++; if (v !== 8'hA5) begin failures++; $display("[TB] FAIL rd_byte1 got=%02h exp=a5", v); end
    recv_byte(v, 1'b1);
    checks++; if (v !== 8'hFF) begin failures++; $display("[TB] FAIL rd_byte2 got=%02h exp=ff", v); end
    idle_bits = '0;
    for (int i = 0; i < 9; i++) begin
      recv_bit(b);
      idle_bits = {idle_bits[7:0], b};
    end
    checks++; if (idle_bits !== 9'h1FF) begin failures++; $display("[TB] FAIL rd_idle_after_nack got=%03h exp=1ff", idle_bits); end
    checks++; if (busy8 !== 1'b1) begin failures++; $display("[TB] FAIL rd_busy_before_stop got=%0b exp=1", busy8); end
    bus_stop();
    checks++; if (busy8 !== 1'b0) begin failures++; $display("[TB] FAIL rd_busy_after_stop got=%0b exp=0", busy8); end
    checks++; if (tx_ready_total - tr_before !== 1) begin failures++; $display("[TB] FAIL rd_tx_ready_pulses got=%0d exp=1", tx_ready_total - tr_before); end
  endtask

  task automatic test_repeated_start();
    logic ack;
    sel4 = 1'b0;
    do_reset();
    bus_start();
    send_byte(8'h20, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    bus_start();
    send_byte(8'h20, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL rs_addr_ack got=%0b exp=0", ack); end
    send_byte(8'h5A, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL rs_data_ack got=%0b exp=0", ack); end
    bus_stop();
    checks++; if (rx_count8 !== 4'd1) begin failures++; $display("[TB] FAIL rs_rx_count got=%0d exp=1", rx_count8); end
    checks++; if (rx_data8 !== 8'h5A) begin failures++; $display("[TB] FAIL rs_rx_data got=%02h exp=5a", rx_data8); end
  endtask

  task automatic test_reset_mid_ack();
    logic ack;
    logic [7:0] addr;
    sel4 = 1'b0;
    do_reset();
    addr = 8'h20;
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(addr[i]);
    checks++; if (oe8 !== 1'b1) begin failures++; $display("[TB] FAIL rm_ack_driven got=%0b exp=1", oe8); end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++; if (oe8 !== 1'b0) begin failures++; $display("[TB] FAIL rm_sda_oe got=%0b exp=0", oe8); end
    checks++; if (busy8 !== 1'b0) begin failures++; $display("[TB] FAIL rm_busy got=%0b exp=0", busy8); end
    checks++; if (rx_count8 !== 4'd0) begin failures++; $display("[TB] FAIL rm_rx_count got=%0d exp=0", rx_count8); end
    @(negedge clk);
    reset = 1'b0;
    wait_q();
    bus_stop();
    bus_start();
    send_byte(8'h20, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL rm_addr_ack got=%0b exp=0", ack); end
    send_byte(8'h33, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("[TB] FAIL rm_data_ack got=%0b exp=0", ack); end
    bus_stop();
    checks++; if (rx_count8 !== 4'd1) begin failures++; $display("[TB] FAIL rm_rx_count_after got=%0d exp=1", rx_count8); end
    checks++; if (rx_data8 !== 8'h33) begin failures++; $display("[TB] FAIL rm_rx_data got=%02h exp=33", rx_data8); end
  endtask

  initial begin
    reset = 1'b1; m_scl = 1'b1; m_sda = 1'b1; sel4 = 1'b0;
    rx_pop8 = 1'b0; rx_pop4 = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    test_reset();
    test_write_burst();
    test_addr_mismatch();
    test_overflow();
    test_read();
    test_repeated_start();
    test_reset_mid_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
